// File: rtl/lsu_ctrl_pkg.sv
// lsu_ctrl_pkg: shared op codes, widths, error codes, FSM states and store-lane helpers
`ifndef LSU_CTRL_DEFINES
`define LSU_CTRL_DEFINES
`define CPU_WIDTH 32
`define MEM_OP_WIDTH 3
`define MEM_LB 3'd0
`define MEM_LH 3'd1
`define MEM_LW 3'd2
`define MEM_LBU 3'd3
`define MEM_LHU 3'd4
`define MEM_SB 3'd5
`define MEM_SH 3'd6
`define MEM_SW 3'd7
`define ERR_MISALIGN 2'd1
`define ERR_TIMEOUT 2'd2
`endif

package lsu_ctrl_pkg;
  localparam int CPU_W = `CPU_WIDTH;
  localparam int OP_W = `MEM_OP_WIDTH;
  localparam logic [OP_W-1:0] OP_LB = `MEM_LB;
  localparam logic [OP_W-1:0] OP_LH = `MEM_LH;
  localparam logic [OP_W-1:0] OP_LW = `MEM_LW;
  localparam logic [OP_W-1:0] OP_LBU = `MEM_LBU;
  localparam logic [OP_W-1:0] OP_LHU = `MEM_LHU;
  localparam logic [OP_W-1:0] OP_SB = `MEM_SB;
  localparam logic [OP_W-1:0] OP_SH = `MEM_SH;
  localparam logic [OP_W-1:0] OP_SW = `MEM_SW;
  localparam logic [1:0] ERR_MISALIGN = `ERR_MISALIGN;
  localparam logic [1:0] ERR_TIMEOUT = `ERR_TIMEOUT;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, RESP, ERR} state_e;

  function automatic logic is_store(input logic [OP_W-1:0] op);
    return op == OP_SB || op == OP_SH || op == OP_SW;
  endfunction

  function automatic logic aligned(input logic [OP_W-1:0] op, input logic [1:0] a);
    return (op == OP_LH || op == OP_LHU || op == OP_SH) ? !a[0] :
           (op == OP_LW || op == OP_SW) ? a == 2'b00 : 1'b1;
  endfunction

  function automatic logic [3:0] st_be(input logic [OP_W-1:0] op, input logic [1:0] a);
    return op == OP_SB ? 4'b0001 << a : op == OP_SH ? 4'b0011 << a : 4'b1111;
  endfunction

  function automatic logic [CPU_W-1:0] st_data(input logic [OP_W-1:0] op, input logic [CPU_W-1:0] d);
    return op == OP_SB ? {4{d[7:0]}} : op == OP_SH ? {2{d[15:0]}} : d;
  endfunction
endpackage

// File: rtl/lsu_ctrl_ld_fmt.sv
// lsu_ld_fmt: selects the addressed byte/halfword of a read word and sign/zero-extends it
module lsu_ld_fmt
  import lsu_ctrl_pkg::*;
(
  input  logic [OP_W-1:0]  op,
  input  logic [1:0]       addr,
  input  logic [CPU_W-1:0] rdata,
  output logic [CPU_W-1:0] data
);
  logic [7:0] b;
  logic [15:0] h;
  assign b = rdata[{addr, 3'b000} +: 8];
  assign h = addr[1] ? rdata[31:16] : rdata[15:0];
  assign data = op == OP_LB  ? {{24{b[7]}}, b} :
                op == OP_LBU ? {24'b0, b} :
                op == OP_LH  ? {{16{h[15]}}, h} :
                op == OP_LHU ? {16'b0, h} : rdata;
endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: single-outstanding load/store controller with alignment check and read timeout
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lsu_valid,
  output logic             lsu_ready,
  input  logic [OP_W-1:0]  lsu_op,
  input  logic [CPU_W-1:0] lsu_addr,
  input  logic [CPU_W-1:0] lsu_wdata,
  input  logic [4:0]       lsu_rd,
  output logic             mem_req,
  output logic             mem_we,
  output logic [CPU_W-1:0] mem_addr,
  output logic [CPU_W-1:0] mem_wdata,
  output logic [3:0]       mem_be,
  input  logic             mem_gnt,
  input  logic             mem_rvalid,
  input  logic [CPU_W-1:0] mem_rdata,
  output logic             wb_valid,
  output logic [4:0]       wb_rd,
  output logic [CPU_W-1:0] wb_data,
  output logic             st_done,
  output logic             err_valid,
  output logic [1:0]       err_code,
  output logic [CPU_W-1:0] err_addr
);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_e state, state_d;
  logic [OP_W-1:0] op_q;
  logic [CPU_W-1:0] addr_q, wdata_q, data_q, fmt;
  logic [4:0] rd_q;
  logic [1:0] code_q;
  logic [CW-1:0] cnt;
  logic st_q, store;

  assign store = is_store(op_q);

  lsu_ld_fmt u_fmt (.op(op_q), .addr(addr_q[1:0]), .rdata(mem_rdata), .data(fmt));

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_d;

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: if (lsu_valid) state_d = aligned(lsu_op, lsu_addr[1:0]) ? REQ : ERR;
      REQ: if (mem_gnt) state_d = store ? IDLE : WAIT;
      WAIT: state_d = mem_rvalid ? RESP : cnt == CW'(TIMEOUT - 1) ? ERR : WAIT;
      default: state_d = IDLE;
    endcase
  end

  // cnt is cleared outside WAIT so each read wait starts counting from zero
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      op_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      rd_q <= '0;
      data_q <= '0;
      code_q <= '0;
      cnt <= '0;
      st_q <= 1'b0;
    end else begin
      if (state == IDLE && lsu_valid) begin
        op_q <= lsu_op;
        addr_q <= lsu_addr;
        wdata_q <= lsu_wdata;
        rd_q <= lsu_rd;
      end
      if (state_d == ERR) code_q <= state == WAIT ? ERR_TIMEOUT : ERR_MISALIGN;
      if (state == WAIT && mem_rvalid) data_q <= fmt;
      cnt <= state == WAIT ? cnt + 1'b1 : '0;
      st_q <= state == REQ && mem_gnt && store;
    end

  assign lsu_ready = state == IDLE;
  assign mem_req = state == REQ;
  assign mem_we = mem_req && store;
  assign mem_addr = mem_req ? {addr_q[CPU_W-1:2], 2'b00} : '0;
  assign mem_be = mem_we ? st_be(op_q, addr_q[1:0]) : '0;
  assign mem_wdata = mem_we ? st_data(op_q, wdata_q) : '0;
  assign wb_valid = state == RESP;
  assign wb_rd = wb_valid ? rd_q : '0;
  assign wb_data = wb_valid ? data_q : '0;
  assign st_done = st_q;
  assign err_valid = state == ERR;
  assign err_code = err_valid ? code_q : '0;
  assign err_addr = err_valid ? addr_q : '0;
endmodule
